load_store_unit: RTL and testbench

Multi-cycle data-memory access stage that sits directly downstream of the single-cycle CPU's ALU. It takes the effective address (ALU result) and the store data (rt value), and it runs byte, halfword and word loads and stores against an internal word-organised memory with a fixed access latency. While an access is in flight it asserts a stall, and it returns the extended load data with a one-cycle completion pulse. It replaces the zero-latency data memory so the core can later be driven against slow memory.

---
 rtl/load_store_unit.sv | 168 ++++++++++++++++
 tb/tb_load_store_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Multi-cycle data-memory access stage placed after the ALU.
//               Performs byte / halfword / word loads and stores against an
//               internal word-organised, little-endian memory with a fixed
//               access latency. Holds the CPU with stall_o while an access
//               is in flight and returns extended load data together with a
//               one-cycle done_o pulse. Misaligned requests are rejected
//               without touching memory and flagged with misalign_o.
//
// Ports       : clk_i      - clock, rising edge
//               rst_i      - asynchronous active-high reset
//               req_i      - access request, sampled only in IDLE
//               we_i       - 1 = store, 0 = load
//               addr_i     - byte address (ALU result)
//               wdata_i    - store data; low byte/half used for sub-word
//               size_i     - 00 byte, 01 half, 10/11 word
//               sign_i     - 1 = sign-extend sub-word loads
//               stall_o    - CPU must hold PC and pipeline state
//               done_o     - one-cycle completion pulse
//               rdata_o    - registered, extended load result
//               misalign_o - pulse with done_o for a rejected access
//
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int MEM_LATENCY = 3,   // 1..15
    parameter int DEPTH       = 128  // words, power of two
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic        sign_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    localparam int          c_IDX_W    = $clog2(DEPTH);
    localparam int          c_AW       = c_IDX_W + 2;   // byte-address bits kept
    localparam logic [3:0]  c_CNT_INIT = 4'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic [c_AW-1:0]   r_addr;
    logic [31:0]       r_wdata;
    logic [1:0]        r_size;
    logic              r_sign;
    logic              r_misalign;
    logic [31:0]       r_rdata;
    logic [31:0]       r_mem [DEPTH];

    logic              w_mis_req;
    logic [c_IDX_W-1:0] w_idx;
    logic [31:0]       w_word;
    logic [31:0]       w_shifted;
    logic [31:0]       w_load;
    logic [31:0]       w_store_word;
    logic              w_unused_addr;

    // Address bits above the memory window alias and are intentionally dropped.
    assign w_unused_addr = &{1'b0, addr_i[31:c_AW]};

    // Half needs addr[0]=0; word (10 or 11) needs addr[1:0]=0.
    assign w_mis_req = ((size_i == 2'b01) && addr_i[0]) ||
                       (size_i[1] && (addr_i[1:0] != 2'b00));

    assign w_idx     = r_addr[c_AW-1:2];
    assign w_word    = r_mem[w_idx];
    // Right-align the addressed lane; halves are aligned so the shift is 0 or 16.
    assign w_shifted = w_word >> {r_addr[1:0], 3'b000};

    always_comb begin
        w_load = w_word;
        case (r_size)
            2'b00:   w_load = {{24{r_sign & w_shifted[7]}},  w_shifted[7:0]};
            2'b01:   w_load = {{16{r_sign & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load = w_word;
        endcase
    end

    // Read-modify-write merge: unselected lanes keep their current contents.
    always_comb begin
        w_store_word = w_word;
        case (r_size)
            2'b00:   w_store_word[{r_addr[1:0], 3'b000} +: 8]  = r_wdata[7:0];
            2'b01:   w_store_word[{r_addr[1],   4'b0000} +: 16] = r_wdata[15:0];
            default: w_store_word = r_wdata;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= 32'd0;
            r_size     <= 2'b00;
            r_sign     <= 1'b0;
            r_misalign <= 1'b0;
            r_rdata    <= 32'd0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 32'd0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        if (w_mis_req) begin
                            r_misalign <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_we       <= we_i;
                            r_addr     <= addr_i[c_AW-1:0];
                            r_wdata    <= wdata_i;
                            r_size     <= size_i;
                            r_sign     <= sign_i;
                            r_misalign <= 1'b0;
                            r_cnt      <= c_CNT_INIT;
                            r_state    <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        // The only edge on which memory or rdata can change, so a
                        // reset earlier in BUSY drops the access cleanly.
                        if (r_we) begin
                            r_mem[w_idx] <= w_store_word;
                        end else begin
                            r_rdata <= w_load;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign stall_o    = ((r_state == S_IDLE) && req_i) || (r_state == S_BUSY);
    assign done_o     = (r_state == S_DONE);
    assign misalign_o = (r_state == S_DONE) && r_misalign;
    assign rdata_o    = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit: directed vector
//               table, a reset-abort sequence, then random accesses compared
//               against a byte-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int LAT   = 3;
    localparam int DEPTH = 128;
    localparam int NBYTE = 4 * DEPTH;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        misalign;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_LATENCY(LAT), .DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (req),
        .we_i       (we),
        .addr_i     (addr),
        .wdata_i    (wdata),
        .size_i     (size),
        .sign_i     (sign),
        .stall_o    (stall),
        .done_o     (done),
        .rdata_o    (rdata),
        .misalign_o (misalign)
    );

    // ---------------- reference model: flat little-endian byte array -------
    logic [7:0]  mb [NBYTE];
    logic [31:0] m_rdata;

    function automatic void model_clear();
        for (int i = 0; i < NBYTE; i++) mb[i] = 8'h00;
        m_rdata = 32'h0;
    endfunction

    function automatic void model_apply(input logic w, input logic [31:0] a,
                                        input logic [31:0] d, input logic [1:0] s,
                                        input logic sg, output logic [31:0] er,
                                        output logic em);
        int  n;
        int  base;
        longint v;
        n    = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        base = int'(a % NBYTE);
        em   = (base % n) != 0;
        if (!em) begin
            if (w) begin
                for (int i = 0; i < n; i++) mb[base + i] = 8'((d >> (8 * i)) & 32'hFF);
            end else begin
                v = 0;
                for (int i = 0; i < n; i++) v = v + (longint'(mb[base + i]) << (8 * i));
                if (sg && n < 4 && ((v >> (8 * n - 1)) & 1) == 1)
                    v = v - (longint'(1) << (8 * n));
                m_rdata = 32'(v);
            end
        end
        er = m_rdata;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one request starting just after a rising edge in IDLE and follow
    // it to completion, checking stall/done timing, misalign and rdata.
    task automatic run_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [1:0] s, input logic sg,
                              input logic [31:0] exp_r, input logic exp_m,
                              input string tag);
        int n;
        int exp_n;
        exp_n = exp_m ? 1 : LAT + 1;
        req = 1'b1; we = w; addr = a; wdata = d; size = s; sign = sg;
        #1;
        check({tag, " stall_req"}, 32'(stall), 32'd1);
        @(posedge clk); #1;
        // Inputs are don't-care once accepted: scramble them.
        req = 1'b0;
        n = 1;
        while (!done && n <= 40) begin
            check({tag, " stall_busy"}, 32'(stall), 32'd1);
            we = 1'($urandom); addr = $urandom; wdata = $urandom;
            size = 2'($urandom); sign = 1'($urandom);
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL %s timeout: no done_o within 40 cycles", tag);
        end else begin
            check({tag, " done_cycle"}, 32'(n), 32'(exp_n));
            check({tag, " stall_done"}, 32'(stall), 32'd0);
            check({tag, " misalign"}, 32'(misalign), 32'(exp_m));
            check({tag, " rdata"}, rdata, exp_r);
            // A request raised during DONE must be ignored.
            req = 1'b1; we = 1'b1; addr = $urandom & 32'hFFFF_FFFC; wdata = $urandom; size = 2'd2;
            #1;
            check({tag, " stall_in_done"}, 32'(stall), 32'd0);
            @(posedge clk); #1;
            req = 1'b0;
            #1;
            check({tag, " idle_after"}, {29'd0, stall, done, misalign}, 32'd0);
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sign;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] er;
        logic        em;

        vecs.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 2'd2, 1'b0, 32'h00000000, 1'b0}); // sw
        vecs.push_back('{1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0}); // lw
        vecs.push_back('{1'b1, 32'h11,  32'h123456AB, 2'd0, 1'b0, 32'hDEADBEEF, 1'b0}); // sb
        vecs.push_back('{1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 32'hDEADABEF, 1'b0}); // lw
        vecs.push_back('{1'b0, 32'h11,  32'h0,        2'd0, 1'b1, 32'hFFFFFFAB, 1'b0}); // lb
        vecs.push_back('{1'b0, 32'h11,  32'h0,        2'd0, 1'b0, 32'h000000AB, 1'b0}); // lbu
        vecs.push_back('{1'b1, 32'h22,  32'h00008001, 2'd1, 1'b0, 32'h000000AB, 1'b0}); // sh
        vecs.push_back('{1'b0, 32'h22,  32'h0,        2'd1, 1'b1, 32'hFFFF8001, 1'b0}); // lh
        vecs.push_back('{1'b0, 32'h22,  32'h0,        2'd1, 1'b0, 32'h00008001, 1'b0}); // lhu
        vecs.push_back('{1'b0, 32'h20,  32'h0,        2'd3, 1'b1, 32'h80010000, 1'b0}); // lw size 11
        vecs.push_back('{1'b0, 32'h06,  32'h0,        2'd2, 1'b0, 32'h80010000, 1'b1}); // lw misaligned
        vecs.push_back('{1'b1, 32'h13,  32'h0000FFFF, 2'd1, 1'b0, 32'h80010000, 1'b1}); // sh misaligned
        vecs.push_back('{1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 32'hDEADABEF, 1'b0}); // memory intact
        vecs.push_back('{1'b0, 32'h12,  32'h0,        2'd1, 1'b1, 32'hFFFFDEAD, 1'b0}); // lh upper half
        vecs.push_back('{1'b1, 32'h200, 32'h55AA55AA, 2'd2, 1'b0, 32'hFFFFDEAD, 1'b0}); // sw alias
        vecs.push_back('{1'b0, 32'h000, 32'h0,        2'd2, 1'b0, 32'h55AA55AA, 1'b0}); // lw alias

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; size = 2'd0; sign = 1'b0;
        model_clear();
        #12;
        check("reset_outputs", {29'd0, stall, done, misalign}, 32'd0);
        check("reset_rdata", rdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // ---------------- directed table ----------------
        foreach (vecs[i]) begin
            model_apply(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].sign, er, em);
            run_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].sign,
                       vecs[i].exp_rdata, vecs[i].exp_mis, $sformatf("vec%0d", i));
        end

        // ---------------- reset during BUSY aborts a store ----------------
        req = 1'b1; we = 1'b1; addr = 32'h10; wdata = 32'hCAFEF00D; size = 2'd2; sign = 1'b0;
        @(posedge clk); #1;          // first BUSY cycle
        req = 1'b0;
        @(posedge clk); #1;          // second BUSY cycle
        rst = 1'b1;
        #1;
        check("abort_outputs", {29'd0, stall, done, misalign}, 32'd0);
        check("abort_rdata", rdata, 32'h0);
        #2;
        rst = 1'b0;
        model_clear();
        @(posedge clk); #1;
        check("abort_idle", {29'd0, stall, done, misalign}, 32'd0);
        run_access(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 32'h00000000, 1'b0, "after_abort_lw");
        run_access(1'b0, 32'h0,  32'h0, 2'd2, 1'b0, 32'h00000000, 1'b0, "after_abort_lw0");

        // ---------------- random vs reference model ----------------
        for (int k = 0; k < 150; k++) begin
            logic        rw;
            logic [31:0] ra;
            logic [31:0] rd;
            logic [1:0]  rs;
            logic        rg;
            rw = 1'($urandom_range(0, 1));
            ra = ($urandom & 32'hFFFF_FE00) | 32'($urandom_range(0, 63));
            rd = $urandom;
            rs = 2'($urandom);
            rg = 1'($urandom);
            if ($urandom_range(0, 3) != 0) ra = ra & ~((rs == 2'd0) ? 32'h0 : (rs == 2'd1) ? 32'h1 : 32'h3);
            model_apply(rw, ra, rd, rs, rg, er, em);
            run_access(rw, ra, rd, rs, rg, er, em, $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
